// File: rtl/lut_config_loader.sv
// lut_config_loader: streams a LUT truth table into a shadow register and commits it atomically
// to the active values bus, with a registered evaluation output z = values[s].
module lut_config_loader #(
   parameter int INPUTS = 4,
   parameter int WIDTH = 1 << INPUTS,
   parameter int WORD = 4,
   localparam int NUM_WORDS = WIDTH / WORD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_start,
   input  logic              cfg_abort,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [WORD-1:0]   cfg_data,
   output logic              cfg_done,
   output logic              cfg_err,
   output logic              busy,
   output logic [WIDTH-1:0]  values,
   input  logic [INPUTS-1:0] s,
   output logic              z
);
   localparam int CW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);
   localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, COMMIT = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shadow;

   assign cfg_ready = state == LOAD;
   assign busy = state != IDLE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         shadow <= '0;
         values <= '0;
         z <= 1'b0;
         cfg_done <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         cfg_done <= state == COMMIT;
         cfg_err <= state == LOAD && cfg_abort;
         z <= values[s];
         if (state == IDLE && cfg_start) begin
            state <= LOAD;
            cnt <= '0;
         end else if (state == LOAD && cfg_abort) begin
            state <= IDLE;
            cnt <= '0;
         end else if (state == LOAD && cfg_valid) begin
            shadow[cnt*WORD +: WORD] <= cfg_data;
            cnt <= cnt == LAST ? '0 : cnt + 1'b1;
            state <= cnt == LAST ? COMMIT : LOAD;
         end else if (state == COMMIT) begin
            values <= shadow;
            state <= IDLE;
         end
      end
   end
endmodule

// File: doc/lut_config_loader.md
Name: lut_config_loader

Overview:
Configuration controller for one LUT predecoder mux.
- Accepts the LUT truth table as a stream of WORD-bit chunks over a valid/ready handshake and assembles them in a shadow register.
- Commits the whole table atomically to the active `values` bus that drives the mux.
- Provides a registered evaluation output `z` from the active table, so a partial load never reaches the LUT datapath.

Parameters:
- INPUTS, 4, number of LUT select inputs.
- WIDTH, 1<<INPUTS, truth-table width in bits.
- WORD, 4, config word width; must divide WIDTH exactly.
- NUM_WORDS, WIDTH/WORD, words per full load; derived, do not override.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- cfg_start, input, 1, single-cycle request to begin a load.
- cfg_abort, input, 1, abandon the load in progress.
- cfg_valid, input, 1, cfg_data is valid.
- cfg_ready, output, 1, loader accepts a word this cycle.
- cfg_data, input, WORD, config word; the first word maps to the LSBs.
- cfg_done, output, 1, one-cycle pulse when the new table is committed.
- cfg_err, output, 1, one-cycle pulse when a load is aborted.
- busy, output, 1, high while in LOAD or COMMIT.
- values, output, WIDTH, active truth table driven to the predecoder.
- s, input, INPUTS, evaluation select.
- z, output, 1, registered values[s].

Behaviour:
- Reset (asynchronous, rst=1):
  - Registers: state=IDLE, word counter=0, shadow=0, values=0.
  - Outputs: z=0, cfg_done=0, cfg_err=0, cfg_ready=0, busy=0.
  - Reset mid-load discards the partial shadow. values returns to 0, not to the prior table.
- State machine: IDLE, LOAD, COMMIT.
- IDLE:
  - cfg_ready=0, busy=0.
  - cfg_valid is ignored; no word is accepted.
  - cfg_abort is ignored.
  - cfg_start=1 -> LOAD with counter=0. The shadow is not cleared; every word is overwritten during the load.
- LOAD:
  - cfg_ready=1, busy=1.
  - Transfer occurs when cfg_valid & cfg_ready: shadow[cnt*WORD +: WORD] <= cfg_data, then cnt++.
  - Transfer of word NUM_WORDS-1 -> COMMIT. The counter width is clog2(NUM_WORDS) with minimum 1. The counter never wraps within a load.
  - cfg_start in LOAD is ignored.
  - cfg_abort=1 -> IDLE, counter=0, cfg_err pulses on the next cycle, values unchanged.
  - cfg_abort takes priority over a transfer in the same cycle; that word is dropped.
  - Gaps in cfg_valid stall the counter with no timeout.
- COMMIT (exactly one cycle):
  - cfg_ready=0, busy=1, cfg_abort ignored.
  - On exit: values <= shadow, cfg_done=1 for the following cycle, next state IDLE.
  - Minimum load time is NUM_WORDS+1 cycles after start accepted.
  - Back-to-back: cfg_start is accepted in the IDLE cycle in which cfg_done is high.
- Evaluation:
  - z <= values[s] every cycle, so latency from s to z is 1 cycle.
  - values changes only at the COMMIT exit edge. z reflects the new table from the edge after that.
  - An out-of-range s cannot occur, because WIDTH = 2^INPUTS.
- cfg_done and cfg_err are registered and never high in the same cycle.

Test Plan:
- Reset, then start and load words 0x1, 0x2, 0x4, 0x8 back-to-back (WIDTH=16, WORD=4) -> cfg_done one cycle after COMMIT, values=16'h8421; s=0 -> z=1, s=5 -> z=1, s=1 -> z=0, s=15 -> z=1, each one cycle later.
- Same load with cfg_valid low for 3 cycles between words 2 and 3 -> cfg_ready stays high, count holds, final values=16'h8421, busy high throughout the load.
- With 16'h8421 active: start, load 0xF, 0xF, then abort -> cfg_err pulses once, values stays 16'h8421, z unchanged; a following full load of 0xA x4 -> values=16'hAAAA.
- Abort asserted together with the 4th word's valid -> word dropped, no COMMIT, cfg_err=1, values unchanged.
- rst asserted after 2 words -> values=0, z=0, cfg_ready=0 immediately without a clock edge; cfg_valid in IDLE is not accepted (cfg_ready=0).
- Start in the cfg_done cycle with load 0x0 x4 -> second commit values=16'h0000; s=0 z sequence: 1 before the commit edge, 0 from the edge after it.
